icache_ctrl: RTL
================

// Module: icache_ctrl
// PURPOSE
//  Direct-mapped, read-only instruction cache between the pipeline fetch port (pc/instr) and a
//  multi-cycle word-serial main memory. A hit returns the instruction combinationally in the same
//  cycle. A miss deasserts cpu_rdy, fetches the 4-word line one word at a time, then resumes.
//  The fetch stage must hold pc and the IF/ID register while cpu_rdy=0.
// PARAMETERS
//  LINES   8   number of cache lines; power of 2, 2..64; index width IDX_W=$clog2(LINES)
//  ADDR_W  16  word-address width
//  DATA_W  16  instruction width; one word per memory beat
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  cpu_addr   in   ADDR_W  fetch word address; offset [1:0], index [IDX_W+1:2], tag = remaining upper bits
//  cpu_re     in   1       fetch request
//  cpu_instr  out  DATA_W  instruction; valid only when cpu_rdy=1, driven 0 otherwise
//  cpu_rdy    out  1       hit this cycle (combinational)
//  inv        in   1       one-cycle pulse: invalidate all lines
//  mem_req    out  1       one-cycle request pulse for one word
//  mem_addr   out  ADDR_W  word address of the request; valid while mem_req=1
//  mem_valid  in   1       one-cycle pulse: mem_rdata holds the requested word
//  mem_rdata  in   DATA_W  returned word
// BEHAVIOUR
//  - Reset: state IDLE, all valid bits 0, beat counter 0, mem_req=0, mem_addr=0, cpu_rdy=0, cpu_instr=0.
//  - hit = (state==IDLE) & cpu_re & valid[idx] & (tag_ram[idx]==tag). cpu_rdy=hit; cpu_instr=data[idx][off].
//  - FSM: IDLE -> REQ when cpu_re & ~hit; latch line base {tag,idx,2'b00} into miss_addr.
//    REQ: mem_req=1, mem_addr=miss_addr|beat; next state WAIT unconditionally.
//    WAIT: hold until mem_valid; write mem_rdata to data[idx][beat]; beat==3 -> DONE, else beat++ and -> REQ.
//    DONE: write tag_ram[idx]; set valid[idx] unless kill; clear beat and kill; -> IDLE.
//  - One outstanding memory request; mem_valid outside WAIT is ignored.
//  - Miss penalty = 4 x (1 + memory latency) + 2 cycles. The hit is seen in the first IDLE cycle after DONE.
//  - The fill always beats 0,1,2,3 (no critical-word-first). The fill uses latched miss_addr.
//    cpu_addr changes mid-fill have no effect. After DONE the current cpu_addr is re-evaluated.
//  - cpu_re dropping mid-fill: the fill still completes and the line is installed.
//  - inv in IDLE: all valid bits clear on that edge; cpu_rdy that cycle still reflects the old valid bits.
//  - inv in REQ/WAIT/DONE: all valid bits clear and kill is set. The in-flight line completes but is
//    not marked valid. inv and the DONE set in the same cycle: inv wins, line stays invalid.
//  - Reset mid-fill: everything returns to reset values at once. A late mem_valid is ignored (state IDLE).
//  - Address bit fields use no arithmetic and cannot overflow. beat is a 2-bit counter and never wraps
//    (it is cleared in DONE).
// STRUCTURE
//  - Package icache_pkg: state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3), WORDS_PER_LINE=4,
//    OFF_W=2, field-extract helper localparams.
//  - Sub-module icache_data_array: LINES*4 x DATA_W storage with asynchronous read and synchronous
//    single-port write (we, widx, woff, wdata). No reset on data.
//  - Controller owns the tag RAM, the valid vector, the FSM, beat, kill and miss_addr.
// TESTING
//  - Reset, cpu_re=1, addr 0x0000: cpu_rdy=0; mem_req with mem_addr 0x0000,1,2,3. Memory latency 3.
//    DONE, then cpu_rdy=1 with cpu_instr = word 0. Total 4*(1+3)+2=18 cycles.
//  - After that fill, sweep addr 0x0001..0x0003: cpu_rdy=1 every cycle, no mem_req, correct words.
//  - Conflict: addr 0x0020 (same idx 0, tag 1) misses. Line refilled from 0x0020..23.
//    Then addr 0x0000 misses again.
//  - inv pulse while in WAIT on beat 2: fill completes, no valid set. The same address re-misses and
//    issues 4 new mem_req.
//  - rst_n low while in WAIT: state IDLE, mem_req=0, all valid clear. A stray mem_valid one cycle later
//    changes nothing. The next fetch of 0x0000 misses.
//  - mem_valid pulsed in IDLE and REQ with garbage data: no array write. Subsequent hits return the
//    original data.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   state_e        : controller FSM encoding
//   WORDS_PER_LINE : words per cache line (one memory beat each)
//   OFF_W          : word-offset field width inside a line
//   OFF_LSB/IDX_LSB: bit positions of the offset and index fields in a word address
package icache_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned OFF_W          = 2;
    localparam int unsigned OFF_LSB        = 0;
    localparam int unsigned IDX_LSB        = OFF_LSB + OFF_W;

endpackage

// File: rtl/icache_data_array.sv
// Instruction data storage: LINES x WORDS_PER_LINE words of DATA_W bits.
// Asynchronous read, synchronous single-port write, no reset on contents.
//   clk     : write clock
//   we_i    : write enable
//   widx_i  : line index to write      woff_i : word offset to write
//   wdata_i : write data
//   ridx_i  : line index to read       roff_i : word offset to read
//   rdata_o : read data (combinational)
module icache_data_array import icache_pkg::*; #(
    parameter int unsigned LINES  = 8,
    parameter int unsigned DATA_W = 16,
    localparam int unsigned IDX_W = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [OFF_W-1:0]  woff_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  ridx_i,
    input  logic [OFF_W-1:0]  roff_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [LINES*WORDS_PER_LINE];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[{widx_i, woff_i}] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[{ridx_i, roff_i}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller.
// Hits return the instruction combinationally; a miss stalls the fetch port (cpu_rdy_o=0) while
// the 4-word line is fetched one word at a time from word-serial memory.
//   clk, rst_n   : clock, asynchronous active-low reset
//   cpu_addr_i   : fetch word address {tag, idx, off}
//   cpu_re_i     : fetch request
//   cpu_instr_o  : instruction, zero unless cpu_rdy_o
//   cpu_rdy_o    : hit this cycle
//   inv_i        : invalidate-all pulse
//   mem_req_o    : one-cycle request for the word at mem_addr_o
//   mem_addr_o   : requested word address (zero when not requesting)
//   mem_valid_i  : returned-word strobe; mem_rdata_i carries the word
module icache_ctrl import icache_pkg::*; #(
    parameter int unsigned LINES  = 8,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_re_i,
    output logic [DATA_W-1:0] cpu_instr_o,
    output logic              cpu_rdy_o,
    input  logic              inv_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_valid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
    localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;
    localparam int unsigned LINE_W  = ADDR_W - OFF_W;

    state_e            state_q, state_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic              kill_q, kill_d;
    // Line address of the miss being filled; the word offset is implicitly zero.
    logic [LINE_W-1:0] miss_addr_q, miss_addr_d;
    logic [TAG_W-1:0]  tag_ram_q [LINES];

    logic [IDX_W-1:0]  cpu_idx, fill_idx;
    logic [OFF_W-1:0]  cpu_off;
    logic [TAG_W-1:0]  cpu_tag, fill_tag;
    logic              hit, arr_we, tag_we;
    logic [DATA_W-1:0] arr_rdata;

    assign cpu_off  = cpu_addr_i[IDX_LSB-1:OFF_LSB];
    assign cpu_idx  = cpu_addr_i[TAG_LSB-1:IDX_LSB];
    assign cpu_tag  = cpu_addr_i[ADDR_W-1:TAG_LSB];
    assign fill_idx = miss_addr_q[IDX_W-1:0];
    assign fill_tag = miss_addr_q[LINE_W-1:IDX_W];

    assign hit = (state_q == StIdle) && cpu_re_i && valid_q[cpu_idx]
                 && (tag_ram_q[cpu_idx] == cpu_tag);

    assign cpu_rdy_o   = hit;
    assign cpu_instr_o = hit ? arr_rdata : '0;
    assign mem_addr_o  = (state_q == StReq) ? {miss_addr_q, beat_q} : '0;

    icache_data_array #(
        .LINES  (LINES),
        .DATA_W (DATA_W)
    ) u_data (
        .clk     (clk),
        .we_i    (arr_we),
        .widx_i  (fill_idx),
        .woff_i  (beat_q),
        .wdata_i (mem_rdata_i),
        .ridx_i  (cpu_idx),
        .roff_i  (cpu_off),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        beat_d      = beat_q;
        kill_d      = kill_q;
        miss_addr_d = miss_addr_q;
        mem_req_o   = 1'b0;
        arr_we      = 1'b0;
        tag_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_re_i && !hit) begin
                    miss_addr_d = cpu_addr_i[ADDR_W-1:OFF_W];
                    state_d     = StReq;
                end
            end
            StReq: begin
                mem_req_o = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                // mem_valid is only honoured here, so stray strobes never touch the array.
                if (mem_valid_i) begin
                    arr_we = 1'b1;
                    if (beat_q == OFF_W'(WORDS_PER_LINE - 1)) begin
                        state_d = StDone;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StDone: begin
                tag_we = 1'b1;
                if (!kill_q) begin
                    valid_d[fill_idx] = 1'b1;
                end
                beat_d  = '0;
                kill_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Invalidate overrides the DONE install. Kill only needs to be remembered when a fill
        // still has a DONE ahead of it; in DONE itself the clear above already covers it.
        if (inv_i) begin
            valid_d = '0;
            if (state_q == StReq || state_q == StWait) begin
                kill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            beat_q      <= '0;
            kill_q      <= 1'b0;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            beat_q      <= beat_d;
            kill_q      <= kill_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Tag RAM needs no reset: entries are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_ram_q[fill_idx] <= fill_tag;
        end
    end

endmodule
